// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, bit-period counter
// width and the bit-period calculation. The receiver uses them now, and the
// transmitter will reuse them later.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per bit period (integer division)
    function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                                 input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial input conditioning: a 2-flop synchronizer, plus a third flop that
// detects falling edges. All flops reset to 1 (line idle level), so releasing
// reset with the line high produces no false edge.
// Ports:
//   clk, rst_n - clock; asynchronous active-low reset
//   rxd        - raw asynchronous serial line
//   rxd_s      - synchronized line level
//   fall       - high for one cycle after the synchronized line goes 1 -> 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q1 <= rxd;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rxd_s = sync_q2;
    assign fall  = prev_q & ~sync_q2;

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1. Frames start on a synchronized falling edge. The start
// bit is checked at its centre, and each later bit is sampled one bit period
// after the previous sample.
// Optional build macro UART_RECV_PARITY_EN adds one even-parity bit after D7
// and a parity_err output.
// Ports:
//   clk, rst_n - clock; asynchronous active-low reset
//   uart_rxd   - serial input, idle high
//   uart_data  - last correctly received byte
//   uart_done  - one-cycle pulse when uart_data is updated
//   frame_err  - one-cycle pulse when the stop bit samples 0
//   parity_err - (UART_RECV_PARITY_EN only) one-cycle pulse on a parity mismatch
module uart_recv
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned UART_BPS = 9600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] uart_data,
    output logic              uart_done,
    output logic              frame_err
`ifdef UART_RECV_PARITY_EN
   ,output logic              parity_err
`endif
);

    localparam int unsigned      BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(BPS_CNT / 2);
    localparam int unsigned      IDX_W    = $clog2(DATA_W);

    logic              rxd_s;
    logic              fall;
    uart_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift;
`ifdef UART_RECV_PARITY_EN
    logic              par_bit;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (uart_rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    // Receive FSM. The pulse outputs default low every cycle, so each pulse is one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            uart_data <= '0;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    // Line back high at the start-bit centre means a glitch, not a frame
                    if (cnt == BIT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rxd_s, shift[DATA_W-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RECV_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RECV_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rxd_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at the stop-bit centre so a start bit that follows directly is not missed
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        frame_err <= ~rxd_s;
`ifdef UART_RECV_PARITY_EN
                        parity_err <= (^shift) != par_bit;
                        if (rxd_s && ((^shift) == par_bit)) begin
                            uart_data <= shift;
                            uart_done <= 1'b1;
                        end
`else
                        if (rxd_s) begin
                            uart_data <= shift;
                            uart_done <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv. A short bit period (25 clocks) keeps the run small.
module tb_uart_recv;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned UART_BPS = 2_000_000;
    localparam int          BPS      = 25;
`ifdef UART_RECV_PARITY_EN
    localparam int          LAT_NOM  = 263;
`else
    localparam int          LAT_NOM  = 238;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       perr_now;
`ifdef UART_RECV_PARITY_EN
    logic       parity_err;
    assign perr_now = parity_err;
`else
    assign perr_now = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .frame_err (frame_err)
`ifdef UART_RECV_PARITY_EN
       ,.parity_err(parity_err)
`endif
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         start_cyc = 0;
    int         last_done_cyc = 0;
    int         done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int         overlap_cnt = 0, wide_cnt = 0, unstable_cnt = 0;
    logic       prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] rx_q[$];
    logic       par_flip = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count pulses, record data, and catch overlap, wide pulses and data drift
    always @(negedge clk) begin
        if (uart_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            rx_q.push_back(uart_data);
        end
        if (frame_err) ferr_cnt++;
        if (perr_now)  perr_cnt++;
        if (uart_done && frame_err) overlap_cnt++;
        if ((uart_done && prev_done) || (frame_err && prev_ferr) || (perr_now && prev_perr))
            wide_cnt++;
        if (rst_n && !uart_done && (uart_data !== prev_data)) unstable_cnt++;
        prev_done = uart_done;
        prev_ferr = frame_err;
        prev_perr = perr_now;
        prev_data = uart_data;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Wait n clocks, then step just past the edge so inputs change away from it
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        uart_rxd  = 1'b0;
        idle(BPS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            idle(BPS);
        end
`ifdef UART_RECV_PARITY_EN
        uart_rxd = (^b) ^ par_flip;
        idle(BPS);
`endif
        uart_rxd = stop_bit;
        idle(BPS);
        uart_rxd = 1'b1;
    endtask

    int d0, f0, p0, lat;

    initial begin
        idle(5);
        chk("rst_data", int'(uart_data), 0);
        chk("rst_done", int'(uart_done), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_state", int'(u_dut.state), int'(IDLE));
        rst_n = 1'b1;
        idle(2 * BPS);
        chk("rel_nopulse", done_cnt + ferr_cnt, 0);

        // Single frame, with latency about 9.5 bit periods from the start edge
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        idle(5);
        chk("a5_done", done_cnt - d0, 1);
        chk("a5_data", int'(uart_data), 8'hA5);
        chk("a5_ferr", ferr_cnt - f0, 0);
        lat = last_done_cyc - start_cyc;
        chk("a5_latency_ok", int'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 6), 1);

        // Back-to-back frames, each with a single stop bit
        rx_q.delete();
        d0 = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(5);
        chk("b2b_done", done_cnt - d0, 3);
        if (rx_q.size() == 3) begin
            chk("b2b_0", int'(rx_q[0]), 8'h00);
            chk("b2b_1", int'(rx_q[1]), 8'hFF);
            chk("b2b_2", int'(rx_q[2]), 8'h55);
        end else begin
            chk("b2b_qsize", rx_q.size(), 3);
        end

        // Glitch shorter than half a bit is rejected as a false start
        d0 = done_cnt; f0 = ferr_cnt;
        uart_rxd = 1'b0;
        idle(8);
        uart_rxd = 1'b1;
        idle(3 * BPS);
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_state", int'(u_dut.state), int'(IDLE));
        send_frame(8'h3C, 1'b1);
        idle(5);
        chk("glitch_next", int'(uart_data), 8'h3C);

        // Stop bit low: framing error, and the byte is discarded
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0);
        idle(2 * BPS);
        chk("ferr_pulse", ferr_cnt - f0, 1);
        chk("ferr_nodone", done_cnt - d0, 0);
        chk("ferr_data", int'(uart_data), 8'h3C);

        // Line held low: one error only
        d0 = done_cnt; f0 = ferr_cnt;
        uart_rxd = 1'b0;
        idle(30 * BPS);
        chk("break_ferr", ferr_cnt - f0, 1);
        chk("break_done", done_cnt - d0, 0);
        uart_rxd = 1'b1;
        idle(3 * BPS);
        chk("break_after", ferr_cnt - f0, 1);

        // Reset during D4 aborts the frame
        d0 = done_cnt; f0 = ferr_cnt;
        uart_rxd = 1'b0;
        idle(BPS);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = i[0];
            idle(BPS);
        end
        uart_rxd = 1'b0;
        idle(BPS / 2);
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        idle(5);
        chk("midrst_data", int'(uart_data), 0);
        rst_n = 1'b1;
        idle(12 * BPS);
        chk("midrst_done", done_cnt - d0, 0);
        chk("midrst_ferr", ferr_cnt - f0, 0);
        send_frame(8'h7E, 1'b1);
        idle(5);
        chk("midrst_next_done", done_cnt - d0, 1);
        chk("midrst_next_data", int'(uart_data), 8'h7E);

`ifdef UART_RECV_PARITY_EN
        // Wrong parity suppresses done; correct parity delivers the byte
        d0 = done_cnt; p0 = perr_cnt;
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        idle(5);
        chk("par_bad_err", perr_cnt - p0, 1);
        chk("par_bad_nodone", done_cnt - d0, 0);
        chk("par_bad_data", int'(uart_data), 8'h7E);
        par_flip = 1'b0;
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h01, 1'b1);
        idle(5);
        chk("par_ok_done", done_cnt - d0, 1);
        chk("par_ok_data", int'(uart_data), 8'h01);
        chk("par_ok_noerr", perr_cnt - p0, 0);
`else
        p0 = perr_cnt;
        chk("no_parity_pulses", p0, 0);
`endif

        chk("overlap", overlap_cnt, 0);
        chk("wide_pulse", wide_cnt, 0);
        chk("data_stable", unstable_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, serial baud rate.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port uart_data  output  8  last correctly received byte.
REQ-007 SHALL have port uart_done  output  1  one-cycle pulse when uart_data is updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-009 SHALL derive BPS_CNT = CLK_FREQ/UART_BPS (integer division), so one bit period is BPS_CNT clk cycles.
REQ-010 SHALL pass uart_rxd through a 2-flop synchronizer before any use; a third flop provides falling-edge detection.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-024).
REQ-012 IDLE: on a synchronized falling edge, clear the bit-period counter and enter START; edges in any other state are ignored.
REQ-013 START: sample the line when the counter reaches BPS_CNT/2 (start-bit centre); if 1, it is a false start, so return to IDLE with no output; if 0, restart the counter and enter DATA.
REQ-014 DATA: sample every BPS_CNT cycles (bit centres), LSB first, into a shift register; after the 8th sample, enter STOP (or PARITY).
REQ-015 STOP: sample at the stop-bit centre. If 1, load uart_data and pulse uart_done on the next cycle. If 0, pulse frame_err on the next cycle and leave uart_data unchanged. Either way, return to IDLE immediately after the sample.
REQ-016 Returning to IDLE at the stop-bit centre SHALL allow back-to-back frames whose start bit directly follows a one-bit stop, with no byte lost.
REQ-017 uart_done and frame_err SHALL never be asserted together and SHALL each be exactly one cycle wide.
REQ-018 uart_data SHALL remain stable between uart_done pulses.
REQ-019 A line held low (break) SHALL produce one frame_err, then wait in IDLE for a new falling edge; there is no repeated error while the line stays low.
REQ-020 The bit-period counter SHALL be at least 16 bits wide and SHALL never wrap within a bit period for BPS_CNT ≤ 65535.

Reset
REQ-021 While rst_n is low: FSM = IDLE, counters = 0, shift register = 0, uart_data = 8'h00, uart_done = 0, frame_err = 0, parity_err = 0, synchronizer flops = 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no done or error pulse; after release, reception resumes on the next falling edge.
REQ-023 Synchronizer flops reset to 1 SHALL NOT generate a spurious falling edge on reset release while the line is high.

Configuration
REQ-024 With macro UART_RECV_PARITY_EN defined: frames carry one even-parity bit after D7, and a PARITY state samples it one bit period after D7. Output port parity_err (1 bit) pulses for one cycle with the stop-bit result on a parity mismatch, and uart_done is then suppressed. Without the macro: no PARITY state and no parity_err port.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state encodings, the BPS_CNT calculation function, and the data width constant (8); the future transmitter reuses them.
REQ-026 One sub-module, uart_rx_sync, SHALL contain the 2-flop synchronizer plus falling-edge detector (outputs: rxd_s, fall).

Verification (CLK_FREQ=50000000, UART_BPS=9600, BPS_CNT=5208)
REQ-027 Send 8'hA5 with a valid stop bit -> one uart_done pulse, uart_data=8'hA5, frame_err=0, done about 9.5 bit periods after the start edge.
REQ-028 Send 8'h00, 8'hFF, 8'h55 back-to-back with one stop bit each -> three uart_done pulses with matching data, in order.
REQ-029 Line-low glitch of 1000 cycles, then high -> no done or error pulse; FSM back in IDLE; next frame 8'h3C received correctly.
REQ-030 Send 8'h81 with stop bit forced 0 -> frame_err pulse, no uart_done, uart_data keeps its previous value.
REQ-031 Assert rst_n low during D4 of a frame, then release and send 8'h7E -> no pulse from the aborted frame, then uart_data=8'h7E.
REQ-032 With UART_RECV_PARITY_EN: send 8'h01 with parity bit 0 -> parity_err pulse, no uart_done; send with parity bit 1 -> uart_done, uart_data=8'h01.
